// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: sizes, FSM states and the
// 3-to-8 select decoder used to fan out the registered grant index.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] dec3to8(input logic [IDX_W-1:0] idx,
                                               input logic en);
    logic [N_REQ-1:0] onehot;
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-side bundle of the 8-way arbiter: request/enable in, grant out.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_vld, timeout
  );

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request scanning ptr+1, ptr+2, ...
// modulo 8. Rotates the request vector, priority-encodes, then rotates back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_enc;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;

  assign w_start = ptr + 1'b1;
  assign w_dbl   = {req, req} >> w_start;
  assign w_rot   = w_dbl[N_REQ-1:0];

  // Scan from the top so the lowest set bit (nearest ptr+1) wins.
  always_comb begin
    w_enc = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_rot[IDX_W'(N_REQ - 1 - i)]) w_enc = IDX_W'(N_REQ - 1 - i);
    end
  end

  assign pick = w_enc + w_start;
  assign any  = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered grant index/valid; a grant is held
// until released. Define ARB_TIMEOUT_EN to revoke grants held MAX_HOLD cycles.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned RESET_PTR = 7
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter8_if.slave bus
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(RESET_PTR);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_vld;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_hold;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold_cnt;
  logic       r_timeout;
`endif

  rr_pick8 u_pick (
    .req  (bus.req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_hold = bus.req[r_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
      r_ptr     <= PTR_RST;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.en && w_any) begin
            r_gnt_idx <= w_pick;
            r_gnt_vld <= 1'b1;
            r_ptr     <= w_pick;
            r_state   <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // A release always takes precedence over an expiry on the same edge.
          if (!w_hold) begin
            r_gnt_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_hold_cnt == HOLD_LAST) begin
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = dec3to8(r_gnt_idx, r_gnt_vld);
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = r_gnt_vld;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus randomized traffic checked
// against a cycle-level round-robin reference model.
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int unsigned TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD), .RESET_PTR(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, who was served last, how long held.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;
  bit m_to;

  function automatic int rr_next(input logic [7:0] r, input int last);
    for (int d = 1; d <= 8; d++) if (r[(last + d) % 8]) return (last + d) % 8;
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 7; m_held = 0; m_to = 1'b0;
  endfunction

  function automatic void model_edge(input logic [7:0] r, input logic e);
    m_to = 1'b0;
    if (m_busy) begin
      if (!r[m_owner]) m_busy = 1'b0;
      else if (TO_EN && m_held == int'(TB_MAX_HOLD)) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else m_held++;
    end else if (e && r != 8'h00) begin
      m_owner = rr_next(r, m_last);
      m_last  = m_owner;
      m_busy  = 1'b1;
      m_held  = 1;
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_busy ? (8'h01 << m_owner) : 8'h00;
    return {g, 3'(m_owner), m_busy, m_to};
  endfunction

  function automatic logic [12:0] act_vec();
    return {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(bus.req, bus.en);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.req = '0; bus.en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (act_vec() !== 13'h0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", act_vec(), 13'h0);
    end
    bus.req = 8'hFF; bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL idle_no_en cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    bus.req = '0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 8'h01; bus.en = 1'b1;
    tick();
    n_cmp++;
    if (act_vec() !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL single_grant: got %h want %h", act_vec(), {8'h01, 3'd0, 1'b1, 1'b0});
    end
    bus.req = 8'h00;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      n_err++; $display("FAIL single_release: got gnt=%h vld=%b want 00/0", bus.gnt, bus.gnt_vld);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic prev_vld;
    do_reset();
    bus.req = 8'hFF; bus.en = 1'b1; prev_vld = 1'b0;
    for (int i = 0; i < 26; i++) begin
      tick();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rr_model cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if (bus.gnt_vld && !prev_vld) order.push_back(int'(bus.gnt_idx));
      prev_vld = bus.gnt_vld;
      bus.req = (m_busy && m_held >= 2) ? (8'hFF & ~(8'h01 << m_owner)) : 8'hFF;
    end
    n_cmp++;
    if (order.size() != 9) begin
      n_err++; $display("FAIL rr_grant_count: got %0d want 9", order.size());
    end
    for (int i = 0; i < order.size() && i < 9; i++) begin
      n_cmp++;
      if (order[i] != i % 8) begin
        n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 8);
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 8'h81; bus.en = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h01) begin
      n_err++; $display("FAIL wrap_ptr7: got %h want 01", bus.gnt);
    end
    bus.req = 8'h00;
    tick();
    bus.req = 8'h81;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h80 || bus.gnt_idx !== 3'd7) begin
      n_err++; $display("FAIL wrap_ptr0: got gnt=%h idx=%0d want 80/7", bus.gnt, bus.gnt_idx);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_en_hold();
    do_reset();
    bus.req = 8'h08; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 8'h08) begin
        n_err++; $display("FAIL en0_hold cyc%0d: got %h want 08", i, bus.gnt);
      end
    end
    bus.req = 8'h00;
    tick();
    bus.req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.gnt !== 8'h00) begin
        n_err++; $display("FAIL en0_block cyc%0d: got %h want 00", i, bus.gnt);
      end
    end
    bus.en = 1'b1;
    tick();
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL en1_resume: got %h want %h", act_vec(), exp_vec());
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 8'h20; bus.en = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h20) begin
      n_err++; $display("FAIL arst_pre: got %h want 20", bus.gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (act_vec() !== 13'h0) begin
      n_err++; $display("FAIL arst_async: got %h want %h", act_vec(), 13'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.req = 8'hFF;
    tick();
    n_cmp++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
      n_err++; $display("FAIL arst_ptr: got gnt=%h idx=%0d want 01/0", bus.gnt, bus.gnt_idx);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    logic       vld[12];
    logic [2:0] idx[12];
    logic       to [12];
    int first_to, streak, nxt;
    do_reset();
    bus.req = 8'h24; bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL to_model cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
      vld[i] = bus.gnt_vld; idx[i] = bus.gnt_idx; to[i] = bus.timeout;
    end
`ifdef ARB_TIMEOUT_EN
    first_to = -1;
    for (int i = 11; i >= 0; i--) if (to[i]) first_to = i;
    streak = 0;
    for (int i = 0; i < 12; i++) if ((first_to < 0 || i < first_to) && vld[i] && idx[i] == 3'd2) streak++;
    n_cmp++;
    if (streak != 4) begin
      n_err++; $display("FAIL to_hold_len: got %0d want 4", streak);
    end
    n_cmp++;
    if (first_to != 4) begin
      n_err++; $display("FAIL to_pulse_pos: got %0d want 4", first_to);
    end
    nxt = (first_to >= 0 && first_to < 11) ? int'({vld[first_to+1], idx[first_to+1]}) : 0;
    n_cmp++;
    if (nxt != 13) begin
      n_err++; $display("FAIL to_next_grant: got vld/idx %0d want 13 (vld=1 idx=5)", nxt);
    end
    n_cmp++;
    if (first_to >= 0 && first_to < 11 && to[first_to+1] !== 1'b0) begin
      n_err++; $display("FAIL to_pulse_width: got 1 want 0 on following cycle");
    end
`else
    first_to = -1; streak = 0; nxt = 0;
    for (int i = 0; i < 12; i++) begin
      if (vld[i] && idx[i] == 3'd2) streak++;
      if (to[i]) nxt++;
    end
    n_cmp++;
    if (streak != 12 || nxt != 0) begin
      n_err++; $display("FAIL unbounded_hold: got held=%0d pulses=%0d want 12/0", streak, nxt);
    end
`endif
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r = r ^ 8'($urandom & $urandom);
      bus.req = r;
      bus.en  = ($urandom_range(0, 9) != 0);
      tick();
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rand cyc%0d req=%h: got %h want %h", i, r, act_vec(), exp_vec());
      end
    end
    bus.req = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    bus.en  = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_en_hold();
    test_async_reset();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
